// File: rtl/tetris_pkg.sv
// Shared playfield types and constants for the board engine and display stage.
package tetris_pkg;
  localparam int BOARD_H   = 16;
  localparam int PREVIEW_X = 12;

  typedef enum logic [2:0] {IDLE, LOCK, SCAN, FLASH, SHIFT} state_t;
  typedef logic [15:0] piece_map_t;
  typedef logic [BOARD_H-1:0][15:0] board_t;

  // Ones in columns 0..w-1; built by loop so w = 16 does not overflow.
  function automatic logic [15:0] col_mask(input int w);
    logic [15:0] m;
    m = '0;
    for (int i = 0; i < 16; i++)
      if (i < w) m[i] = 1'b1;
    return m;
  endfunction
endpackage

// File: rtl/row_full_detect.sv
// Flags every board row whose playable columns are all occupied.
module row_full_detect
  import tetris_pkg::*;
(
  input  board_t      board,
  input  logic [15:0] col_mask,
  output logic [15:0] full_mask
);
  always_comb begin
    full_mask = '0;
    for (int y = 0; y < BOARD_H; y++)
      full_mask[y] = ((board[y] & col_mask) == col_mask);
  end
endmodule

// File: rtl/board_lock_clear.sv
// Settled-block board: merges landed pieces, flashes full rows, collapses them.
//   state | meaning
//   IDLE  | waiting for a landed piece (ready unless game over)
//   LOCK  | OR clipped piece into board, detect overlap
//   SCAN  | latch full-row mask
//   FLASH | show full rows red+green for FLASH_CYCLES cycles
//   SHIFT | drop rows above the lowest full row by one, one row per cycle
module board_lock_clear
  import tetris_pkg::*;
#(
  parameter int FIELD_W      = 10,
  parameter int FLASH_CYCLES = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        lock_valid,
  output logic        lock_ready,
  input  piece_map_t  lock_map,
  input  logic [3:0]  lock_x,
  input  logic [3:0]  lock_y,
  output board_t      occ,
  output board_t      RedPixels_board,
  output board_t      GrnPixels_board,
  output logic        lines_done,
  output logic [2:0]  lines_count,
  output logic [15:0] lines_total,
  output logic        game_over
);
  localparam logic [15:0] COL_MASK   = col_mask(FIELD_W);
  localparam logic [15:0] FLASH_LOAD = 16'(FLASH_CYCLES - 1);

  state_t      state, state_nxt;
  board_t      board, board_nxt, piece_cells, shift_board;
  piece_map_t  lat_map;
  logic [3:0]  lat_x, lat_y, row_sel;
  logic [15:0] full_mask, full_mask_r, shift_mask, flash_cnt;
  logic [2:0]  count, count_nxt;
  logic        overlap, done_entry;

  row_full_detect u_row_full_detect (
    .board     (board),
    .col_mask  (COL_MASK),
    .full_mask (full_mask)
  );

  // Piece cells are placed in 5-bit space so off-field cells drop instead of wrapping.
  always_comb begin : lock_cells
    logic [4:0] ax, ay;
    piece_cells = '0;
    for (int dy = 0; dy < 4; dy++)
      for (int dx = 0; dx < 4; dx++) begin
        ax = {1'b0, lat_x} + 5'(dx);
        ay = {1'b0, lat_y} + 5'(dy);
        if (lat_map[15 - (dy * 4 + dx)] && (ax < 5'(FIELD_W)) && !ay[4])
          piece_cells[ay[3:0]][ax[3:0]] = 1'b1;
      end
  end

  assign overlap = |(piece_cells & board);

  always_comb begin
    row_sel = '0;
    for (int y = 0; y < BOARD_H; y++)
      if (full_mask_r[y]) row_sel = 4'(y);
  end

  always_comb begin
    shift_board    = board;
    shift_mask     = full_mask_r;
    shift_board[0] = '0;
    shift_mask[0]  = 1'b0;
    for (int y = 1; y < BOARD_H; y++)
      if (4'(y) <= row_sel) begin
        shift_board[y] = board[y-1];
        shift_mask[y]  = full_mask_r[y-1];
      end
  end

  always_comb begin
    board_nxt = board;
    count_nxt = count;
    case (state)
      LOCK:    board_nxt = board | piece_cells;
      SHIFT: begin
        board_nxt = shift_board;
        count_nxt = count + 3'd1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (lock_valid && lock_ready) state_nxt = LOCK;
      LOCK:    state_nxt = SCAN;
      SCAN:    state_nxt = (full_mask == '0) ? IDLE : FLASH;
      FLASH:   if (flash_cnt == '0) state_nxt = SHIFT;
      SHIFT:   if (shift_mask == '0) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    lock_ready      = (state == IDLE) && !game_over;
    occ             = board;
    RedPixels_board = '0;
    GrnPixels_board = '0;
    for (int y = 0; y < BOARD_H; y++) begin
      if (state == FLASH && full_mask_r[y]) begin
        RedPixels_board[y] = COL_MASK;
        GrnPixels_board[y] = COL_MASK;
      end else begin
        RedPixels_board[y] = board[y] & COL_MASK;
      end
    end
  end

  assign done_entry = ((state == SCAN) || (state == SHIFT)) && (state_nxt == IDLE);

  always_ff @(posedge clk) begin
    if (reset) begin
      board       <= '0;
      lat_map     <= '0;
      lat_x       <= '0;
      lat_y       <= '0;
      full_mask_r <= '0;
      flash_cnt   <= '0;
      count       <= '0;
      lines_done  <= 1'b0;
      lines_count <= '0;
      lines_total <= '0;
      game_over   <= 1'b0;
    end else begin
      board      <= board_nxt;
      lines_done <= done_entry;
      case (state)
        IDLE: if (lock_valid && lock_ready) begin
          lat_map <= lock_map;
          lat_x   <= lock_x;
          lat_y   <= lock_y;
          count   <= '0;
        end
        LOCK: if (overlap) game_over <= 1'b1;
        SCAN: begin
          full_mask_r <= full_mask;
          flash_cnt   <= FLASH_LOAD;
        end
        FLASH: if (flash_cnt != '0) flash_cnt <= flash_cnt - 16'd1;
        SHIFT: begin
          full_mask_r <= shift_mask;
          count       <= count_nxt;
          if (lines_total != 16'hFFFF) lines_total <= lines_total + 16'd1;
        end
        default: ;
      endcase
      if (done_entry) begin
        lines_count <= count_nxt;
        if (|board_nxt[0]) game_over <= 1'b1;
      end
    end
  end
endmodule
